// File: rtl/spi_ram_burst.sv
// Command-decoded single-port RAM behind the SPI slave.
// Burst pointers, held tx handshake, overrun and range error pulses.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              overrun,
  output logic              addr_err
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } tx_state_e;

  localparam logic [ADDR_SIZE:0] DEPTH =
    (ADDR_SIZE+1)'(MEM_DEPTH);

  tx_state_e state;

  logic [DATA_W-1:0]    mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;

  logic [1:0]           cmd;
  logic [DATA_W-1:0]    pl;
  logic [ADDR_SIZE-1:0] pl_addr;
  logic wr_adr, wr_dat, rd_adr, rd_cmd;
  logic rd_acc, wr_ok, rd_ok;

  assign cmd     = din[DATA_W+1:DATA_W];
  assign pl      = din[DATA_W-1:0];
  assign pl_addr = din[ADDR_SIZE-1:0];

  assign wr_adr = rx_valid && (cmd == 2'b00);
  assign wr_dat = rx_valid && (cmd == 2'b01);
  assign rd_adr = rx_valid && (cmd == 2'b10);
  assign rd_cmd = rx_valid && (cmd == 2'b11);

  // A read slot frees up when the held word is taken this same cycle.
  assign rd_acc = rd_cmd && (state == IDLE || tx_ready);

  assign wr_ok = {1'b0, wr_ptr} < DEPTH;
  assign rd_ok = {1'b0, rd_ptr} < DEPTH;

  assign tx_valid = (state == FULL);

  // Out-of-range pointers fall back to 0, same as the last word.
  function automatic logic [ADDR_SIZE-1:0] bump(
    input logic [ADDR_SIZE-1:0] p
  );
    if ({1'b0, p} >= DEPTH - 1'b1) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_dat && wr_ok) mem[wr_ptr] <= pl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dout     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overrun  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      overrun  <= rd_cmd && !rd_acc;
      addr_err <= (wr_dat && !wr_ok) ||
                  (rd_acc && !rd_ok);

      unique case (1'b1)
        wr_adr: wr_ptr <= pl_addr;
        wr_dat: if (AUTO_INC != 0) wr_ptr <= bump(wr_ptr);
        rd_adr: rd_ptr <= pl_addr;
        rd_acc: if (AUTO_INC != 0) rd_ptr <= bump(rd_ptr);
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (rd_acc) begin
            dout  <= rd_ok ? mem[rd_ptr] : '0;
            state <= FULL;
          end
        end
        FULL: begin
          if (rd_acc) begin
            dout <= rd_ok ? mem[rd_ptr] : '0;
          end else if (tx_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: directed plan steps plus random traffic,
// run on a full-depth and a 200-word instance against a word-level model.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid, tx_ready;

  logic [7:0] dout_a, dout_b;
  logic       tv_a, tv_b, ov_a, ov_b, ae_a, ae_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_ram_burst #(
    .DATA_W(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .din(din),
    .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout_a), .tx_valid(tv_a),
    .overrun(ov_a), .addr_err(ae_a)
  );

  spi_ram_burst #(
    .DATA_W(8), .ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .din(din),
    .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout_b), .tx_valid(tv_b),
    .overrun(ov_b), .addr_err(ae_b)
  );

  // Reference model: index 0 = 256 words, index 1 = 200 words.
  int         depth [2] = '{256, 200};
  logic [7:0] mmem  [2][256];
  int         wp [2], rp [2];
  bit         mv [2], mov [2], mae [2];
  logic [7:0] md [2];

  function automatic int nxt(int k, int p);
    return (p >= depth[k] - 1) ? 0 : p + 1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      wp[k] = 0; rp[k] = 0; mv[k] = 0;
      md[k] = 8'h00; mov[k] = 0; mae[k] = 0;
    end
  endfunction

  function automatic void step(int k, bit rxv, logic [1:0] c,
                               logic [7:0] p, bit rdy);
    bit took;
    took   = 0;
    mov[k] = 0;
    mae[k] = 0;
    if (rxv) begin
      case (c)
        2'd0: wp[k] = p;
        2'd1: begin
          if (wp[k] < depth[k]) mmem[k][wp[k]] = p;
          else mae[k] = 1;
          wp[k] = nxt(k, wp[k]);
        end
        2'd2: rp[k] = p;
        default: begin
          if (!mv[k] || rdy) begin
            if (rp[k] < depth[k]) md[k] = mmem[k][rp[k]];
            else begin md[k] = 8'h00; mae[k] = 1; end
            mv[k] = 1;
            took  = 1;
            rp[k] = nxt(k, rp[k]);
          end else begin
            mov[k] = 1;
          end
        end
      endcase
    end
    if (!took && mv[k] && rdy) mv[k] = 0;
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    if ($isunknown(exp)) return;
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic check_all();
    chk("a.dout", dout_a, md[0]);
    chk("a.tx_valid", {7'd0, tv_a}, {7'd0, mv[0]});
    chk("a.overrun", {7'd0, ov_a}, {7'd0, mov[0]});
    chk("a.addr_err", {7'd0, ae_a}, {7'd0, mae[0]});
    chk("b.dout", dout_b, md[1]);
    chk("b.tx_valid", {7'd0, tv_b}, {7'd0, mv[1]});
    chk("b.overrun", {7'd0, ov_b}, {7'd0, mov[1]});
    chk("b.addr_err", {7'd0, ae_b}, {7'd0, mae[1]});
  endtask

  task automatic cyc(bit rxv, logic [1:0] c, logic [7:0] p, bit rdy);
    rx_valid = rxv;
    din      = {c, p};
    tx_ready = rdy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) step(k, rxv, c, p, rdy);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; din = '0;
    model_reset();
    #12;
    chk("rst.dout", dout_a, 8'h00);
    chk("rst.tx_valid", {7'd0, tv_a}, 8'h00);
    chk("rst.flags", {6'd0, ov_b, ae_b}, 8'h00);
    rst_n = 1'b1;

    // 1: write then read one word
    cyc(1, 2'd0, 8'h10, 1);
    cyc(1, 2'd1, 8'hA5, 1);
    cyc(1, 2'd2, 8'h10, 1);
    cyc(1, 2'd3, 8'h00, 1);
    chk("p1.dout", dout_a, 8'hA5);
    chk("p1.tv", {7'd0, tv_a}, 8'h01);
    cyc(0, 2'd0, 8'h00, 1);
    chk("p1.tv_drop", {7'd0, tv_a}, 8'h00);

    // 2: burst across the top of memory
    cyc(1, 2'd0, 8'hFE, 1);
    cyc(1, 2'd1, 8'h11, 1);
    cyc(1, 2'd1, 8'h22, 1);
    cyc(1, 2'd1, 8'h33, 1);
    cyc(1, 2'd2, 8'hFE, 1);
    cyc(1, 2'd3, 8'h00, 1);
    chk("p2.r0", dout_a, 8'h11);
    cyc(1, 2'd3, 8'h00, 1);
    chk("p2.r1", dout_a, 8'h22);
    cyc(1, 2'd3, 8'h00, 1);
    chk("p2.r2", dout_a, 8'h33);
    cyc(0, 2'd0, 8'h00, 1);

    // 3: backpressure and overrun
    cyc(1, 2'd0, 8'h20, 0);
    cyc(1, 2'd1, 8'h5A, 0);
    cyc(1, 2'd1, 8'h6B, 0);
    cyc(1, 2'd1, 8'h7C, 0);
    cyc(1, 2'd2, 8'h20, 0);
    cyc(1, 2'd3, 8'h00, 0);
    chk("p3.dout", dout_a, 8'h5A);
    cyc(1, 2'd3, 8'h00, 0);
    chk("p3.ovr", {7'd0, ov_a}, 8'h01);
    chk("p3.hold", dout_a, 8'h5A);
    cyc(0, 2'd0, 8'h00, 0);
    chk("p3.ovr_pulse", {7'd0, ov_a}, 8'h00);
    cyc(0, 2'd0, 8'h00, 1);
    chk("p3.tv_drop", {7'd0, tv_a}, 8'h00);
    cyc(1, 2'd3, 8'h00, 0);
    chk("p3.no_adv", dout_a, 8'h6B);

    // 4: take and refill in one cycle
    cyc(1, 2'd3, 8'h00, 1);
    chk("p4.tv", {7'd0, tv_a}, 8'h01);
    chk("p4.dout", dout_a, 8'h7C);

    // 5: out-of-range access on the 200-word instance
    cyc(1, 2'd0, 8'hC8, 1);
    cyc(1, 2'd1, 8'h77, 1);
    chk("p5.werr", {7'd0, ae_b}, 8'h01);
    chk("p5.a_ok", {7'd0, ae_a}, 8'h00);
    cyc(1, 2'd2, 8'hC8, 1);
    cyc(1, 2'd3, 8'h00, 1);
    chk("p5.rdout", dout_b, 8'h00);
    chk("p5.rtv", {7'd0, tv_b}, 8'h01);
    chk("p5.rerr", {7'd0, ae_b}, 8'h01);
    chk("p5.a_dout", dout_a, 8'h77);

    // 6: asynchronous reset while holding data
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("p6.dout", dout_a, 8'h00);
    chk("p6.tv", {7'd0, tv_a}, 8'h00);
    chk("p6.b_tv", {7'd0, tv_b}, 8'h00);
    #2 rst_n = 1'b1;
    cyc(1, 2'd1, 8'h99, 0);
    cyc(1, 2'd3, 8'h00, 1);
    chk("p6.addr0", dout_a, 8'h99);

    // Fill memory, then random traffic
    cyc(1, 2'd0, 8'h00, 0);
    for (int i = 0; i < 256; i++)
      cyc(1, 2'd1, 8'($urandom), 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, 2'($urandom),
          8'($urandom), $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
